sd_dac: RTL and testbench

- First-order sigma-delta DAC. It is the output-direction counterpart of the XADC sample path.
- Accepts 16-bit unsigned (offset-binary) samples over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per sample period and modulates it onto a 1-bit pin; an external RC filter reconstructs the analog level.
- Sits beside the adc block in top-level designs; can be fed directly from s_out for loopback.

---
 rtl/sd_dac_if.sv | 11 +
 rtl/sd_dac.sv | 126 ++++++++++++
 tb/tb_sd_dac.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dac_if.sv
// Sample stream into the sigma-delta DAC: offset-binary samples on a valid/ready handshake.
interface sd_dac_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] s_in;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_in, output s_valid, input s_ready);
    modport slave  (input s_in, input s_valid, output s_ready);
endinterface

// File: rtl/sd_dac.sv
// First-order sigma-delta DAC: FIFO-buffered samples released one per RATE_DIV cycles onto a 1-bit pin.
// s_ready is !full only (no pass-through); define SD_DAC_DITHER_EN to add LFSR dither into the modulator.
module sd_dac #(
    parameter int DATA_W     = 16,
    parameter int RATE_DIV   = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    sd_dac_if.slave                     s_if,
    output logic                        dac_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    output logic [7:0]                  underrun_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(RATE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RATE_DIV - 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_active;
    logic [DATA_W-1:0] r_acc;
    logic              r_dac;
    logic              r_underrun;
    logic [7:0]        r_ucnt;

    logic w_full;
    logic w_empty;
    logic w_tick;
    logic w_push;
    logic w_pop;
    logic w_carry;
    logic [DATA_W-1:0] w_acc_next;

    assign w_full  = (r_level == DEPTH_LVL);
    assign w_empty = (r_level == '0);
    assign w_tick  = (r_cnt == CNT_MAX);
    // A pop freeing a slot on the same edge does not let a full FIFO accept.
    assign w_push  = s_if.s_valid && !w_full;
    assign w_pop   = w_tick && !w_empty;

    assign s_if.s_ready = !w_full;

`ifdef SD_DAC_DITHER_EN
    logic [15:0]       r_lfsr;
    logic [DATA_W+1:0] w_sum;

    assign w_sum      = {2'b00, r_acc} + {2'b00, r_active} + {{DATA_W{1'b0}}, r_lfsr[1:0]};
    assign w_carry    = |w_sum[DATA_W+1:DATA_W];
    assign w_acc_next = w_sum[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    logic [DATA_W:0] w_sum;

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_active};
    assign w_carry    = w_sum[DATA_W];
    assign w_acc_next = w_sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_if.s_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_active   <= '0;
            r_acc      <= '0;
            r_dac      <= 1'b0;
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
            r_acc      <= w_acc_next;
            r_dac      <= w_carry;
            r_underrun <= w_tick && w_empty;
            if (w_pop) begin
                r_active <= r_mem[r_rd_ptr];
            end
            if (w_tick && w_empty && (r_ucnt != 8'hFF)) begin
                r_ucnt <= r_ucnt + 1'b1;
            end
        end
    end

    assign dac_out      = r_dac;
    assign fifo_level   = r_level;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ucnt;
endmodule

// File: tb/tb_sd_dac.sv
// Directed bench for sd_dac: scoreboard of accepted samples feeds a reference modulator checked every cycle.
module tb_sd_dac;
    localparam int RATE  = 16;
    localparam int DEPTH = 4;
`ifdef SD_DAC_DITHER_EN
    localparam int TOL = 4;
`else
    localparam int TOL = 0;
`endif

    logic       clk;
    logic       rst;
    logic       dac_out;
    logic [2:0] fifo_level;
    logic       underrun;
    logic [7:0] underrun_cnt;

    sd_dac_if #(.DATA_W(16)) s_if ();

    sd_dac #(.DATA_W(16), .RATE_DIV(RATE), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_if         (s_if.slave),
        .dac_out      (dac_out),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          edge_n = 0;
    int          ones   = 0;
    int          exp_ucnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] ref_acc    = '0;
    logic [15:0] ref_active = '0;
    logic        exp_dac    = 1'b0;
    logic        exp_under  = 1'b0;
    logic [15:0] fv [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp_v, input int tol);
        checks++;
        assert ((obs >= exp_v - tol) && (obs <= exp_v + tol)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (+/-%0d)", tag, obs, exp_v, tol);
        end
    endtask

    // One clock: predict the edge from pre-edge inputs, then compare outputs 1 time unit after it.
    task automatic step();
        bit          tick_now;
        bit          take;
        logic [15:0] pv;
        logic [16:0] sum;
        tick_now = ((edge_n + 1) % RATE) == 0;
        take     = (s_if.s_valid === 1'b1) && (exp_q.size() < DEPTH);
        pv       = s_if.s_in;
        @(posedge clk);
        #1;
        edge_n++;
        sum       = {1'b0, ref_acc} + {1'b0, ref_active};
        ref_acc   = sum[15:0];
        exp_dac   = sum[16];
        exp_under = 1'b0;
        if (tick_now) begin
            if (exp_q.size() != 0) begin
                ref_active = exp_q.pop_front();
            end else begin
                exp_under = 1'b1;
                if (exp_ucnt < 255) exp_ucnt++;
            end
        end
        if (take) exp_q.push_back(pv);
        ones += (dac_out === 1'b1) ? 1 : 0;
`ifndef SD_DAC_DITHER_EN
        chk("dac_bit", {31'd0, dac_out}, {31'd0, exp_dac});
`endif
        chk("underrun", {31'd0, underrun}, {31'd0, exp_under});
        chk("ucnt", {24'd0, underrun_cnt}, exp_ucnt);
        chk("level", {29'd0, fifo_level}, exp_q.size());
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic do_reset();
        s_if.s_valid = 1'b0;
        s_if.s_in    = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        edge_n     = 0;
        ones       = 0;
        exp_ucnt   = 0;
        exp_q.delete();
        ref_acc    = '0;
        ref_active = '0;
        exp_dac    = 1'b0;
        exp_under  = 1'b0;
    endtask

    initial begin
        fv[0] = 16'hF000; fv[1] = 16'h1234; fv[2] = 16'h8001; fv[3] = 16'hFFFF; fv[4] = 16'h0000;

        // Reset state
        do_reset();
        chk("rst_level", {29'd0, fifo_level}, 0);
        chk("rst_ready", {31'd0, s_if.s_ready}, 1);
        chk("rst_dac", {31'd0, dac_out}, 0);
        chk("rst_urun", {31'd0, underrun}, 0);
        chk("rst_ucnt", {24'd0, underrun_cnt}, 0);

        // Mid-scale: alternating bitstream, exact count, underruns saturate meanwhile
        s_if.s_valid = 1'b1; s_if.s_in = 16'h8000;
        step();
        s_if.s_valid = 1'b0;
        chk("mid_push_level", {29'd0, fifo_level}, 1);
        run_to(16);
        chk("mid_pop_level", {29'd0, fifo_level}, 0);
        ones = 0;
        step();
`ifndef SD_DAC_DITHER_EN
        chk("mid_first", {31'd0, dac_out}, 0);
`endif
        step();
`ifndef SD_DAC_DITHER_EN
        chk("mid_second", {31'd0, dac_out}, 1);
`endif
        run_to(16 + 65536);
        chk_tol("mid_ones", ones, 32768, TOL);
        chk("ucnt_sat", {24'd0, underrun_cnt}, 255);

        // Extremes
        do_reset();
        s_if.s_valid = 1'b1; s_if.s_in = 16'h0000;
        step();
        s_if.s_valid = 1'b0;
        run_to(16);
        ones = 0;
        run_to(16 + 4096);
        chk_tol("zero_ones", ones, 0, TOL);
        s_if.s_valid = 1'b1; s_if.s_in = 16'hFFFF;
        step();
        s_if.s_valid = 1'b0;
        run_to(4128);
        ones = 0;
        run_to(4128 + 4096);
        chk_tol("max_ones", ones, 4095, TOL);

        // Full FIFO: 4 accepted, 5th dropped even across the popping tick
        do_reset();
        s_if.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.s_in = fv[i];
            step();
            if (i == 3) begin
                chk("full_level4", {29'd0, fifo_level}, 4);
                chk("full_ready0", {31'd0, s_if.s_ready}, 0);
            end
        end
        chk("full_5th_dropped", {29'd0, fifo_level}, 4);
        run_to(15);
        chk("full_ready_hold", {31'd0, s_if.s_ready}, 0);
        step();
        chk("full_tick_level", {29'd0, fifo_level}, 3);
        chk("full_tick_ready", {31'd0, s_if.s_ready}, 1);
        s_if.s_valid = 1'b0;
        run_to(96);
        chk("full_drain_ucnt", {24'd0, underrun_cnt}, 2);

        // Underrun: one sample, three ticks, active value held
        do_reset();
        s_if.s_valid = 1'b1; s_if.s_in = 16'h4000;
        step();
        s_if.s_valid = 1'b0;
        run_to(16);
        chk("urun_tick1", {31'd0, underrun}, 0);
        ones = 0;
        run_to(32);
        chk("urun_tick2", {31'd0, underrun}, 1);
        chk("urun_cnt1", {24'd0, underrun_cnt}, 1);
        run_to(48);
        chk("urun_tick3", {31'd0, underrun}, 1);
        chk("urun_cnt2", {24'd0, underrun_cnt}, 2);
        chk_tol("urun_held_ones", ones, 8, TOL);
        step();
        chk("urun_pulse_end", {31'd0, underrun}, 0);

        // Coincident: push on an empty tick, then push+pop at level 2
        do_reset();
        run_to(15);
        s_if.s_valid = 1'b1; s_if.s_in = 16'h2000;
        step();
        s_if.s_valid = 1'b0;
        chk("coinc_urun", {31'd0, underrun}, 1);
        chk("coinc_level", {29'd0, fifo_level}, 1);
        run_to(32);
        chk("coinc_loaded", {29'd0, fifo_level}, 0);
        s_if.s_valid = 1'b1; s_if.s_in = 16'h1111;
        step();
        s_if.s_in = 16'h2222;
        step();
        s_if.s_valid = 1'b0;
        chk("pp_level_pre", {29'd0, fifo_level}, 2);
        run_to(47);
        s_if.s_valid = 1'b1; s_if.s_in = 16'h3333;
        step();
        s_if.s_valid = 1'b0;
        chk("pp_level", {29'd0, fifo_level}, 2);

        // Asynchronous reset with level 3 and a non-zero underrun count
        s_if.s_valid = 1'b1; s_if.s_in = 16'h5555;
        step();
        s_if.s_valid = 1'b0;
        chk("mrst_pre_level", {29'd0, fifo_level}, 3);
        #3;
        rst = 1'b1;
        #1;
        chk("mrst_level", {29'd0, fifo_level}, 0);
        chk("mrst_ready", {31'd0, s_if.s_ready}, 1);
        chk("mrst_dac", {31'd0, dac_out}, 0);
        chk("mrst_ucnt", {24'd0, underrun_cnt}, 0);
        do_reset();
        run_to(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
